// File: rtl/stb_to_pulse_pkg.sv
// rtl/stb_to_pulse_pkg.sv - shared state type and width helpers for stb_to_pulse
package stb_to_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int timer_width(input int high_clks, input int low_clks);
    return $clog2(max_int(high_clks, low_clks) + 1);
  endfunction

  function automatic int pending_width(input int queue_depth);
    return $clog2(queue_depth + 1);
  endfunction

endpackage

// File: rtl/stb_to_pulse_phase_timer.sv
// rtl/stb_to_pulse_phase_timer.sv - loadable down-counter shared by the HIGH and GAP phases
module stb_to_pulse_phase_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Loading N-1 makes a phase last exactly N cycles including the load cycle's successor.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/stb_to_pulse.sv
// rtl/stb_to_pulse.sv - regenerates fixed-width pulses with a guaranteed low gap from 1-cycle strobes
// Optional queue-cancel input enabled by STB_TO_PULSE_CANCEL_EN.
module stb_to_pulse
  import stb_to_pulse_pkg::*;
#(
  parameter int HIGH_CLKS   = 625000,
  parameter int LOW_CLKS    = 625000,
  parameter int QUEUE_DEPTH = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
`ifdef STB_TO_PULSE_CANCEL_EN
  input  logic i_cancel,
`endif
  output logic o_pulse,
  output logic o_busy,
  output logic o_overflow
);

  localparam int TW = timer_width(HIGH_CLKS, LOW_CLKS);
  localparam int PW = pending_width(QUEUE_DEPTH);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CLKS - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CLKS - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(QUEUE_DEPTH);

  pulse_state_t  r_state;
  logic [PW-1:0] r_pending;
  logic          r_pulse;
  logic          r_overflow;

  logic          w_cancel;
  logic          w_done;
  logic          w_pend_nz;
  logic          w_last_gap;
  logic          w_queueing;
  logic          w_restart;
  logic          w_load;
  logic [TW-1:0] w_load_val;

`ifdef STB_TO_PULSE_CANCEL_EN
  assign w_cancel = i_cancel;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_pend_nz  = (r_pending != '0);
  assign w_last_gap = (r_state == GAP) && w_done;
  assign w_queueing = (r_state == HIGH) || ((r_state == GAP) && !w_done);
  // A cancel on the last gap cycle empties the queue, so the block falls back to IDLE.
  assign w_restart  = w_last_gap && !w_cancel && (w_pend_nz || i_stb);

  always_comb begin
    w_load     = 1'b0;
    w_load_val = HIGH_LOAD;
    case (r_state)
      IDLE: w_load = i_stb;
      HIGH: begin
        if (w_done) begin
          w_load     = 1'b1;
          w_load_val = LOW_LOAD;
        end
      end
      GAP:  w_load = w_restart;
      default: w_load = 1'b0;
    endcase
  end

  stb_to_pulse_phase_timer #(
    .W(TW)
  ) u_phase_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_pulse    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;

      if (w_queueing) begin
        if (w_cancel) begin
          r_pending <= '0;
        end else if (i_stb) begin
          if (r_pending == PEND_MAX) begin
            r_overflow <= 1'b1;
          end else begin
            r_pending <= r_pending + PW'(1);
          end
        end
      end

      case (r_state)
        IDLE: begin
          r_pulse <= 1'b0;
          if (i_stb) begin
            r_state <= HIGH;
            r_pulse <= 1'b1;
          end
        end
        HIGH: begin
          if (w_done) begin
            r_state <= GAP;
            r_pulse <= 1'b0;
          end
        end
        GAP: begin
          if (w_restart) begin
            r_state <= HIGH;
            r_pulse <= 1'b1;
            // A same-cycle strobe replaces the dequeued entry, leaving the count unchanged.
            if (w_pend_nz && !i_stb) begin
              r_pending <= r_pending - PW'(1);
            end
          end else if (w_last_gap) begin
            r_state   <= IDLE;
            r_pending <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pulse   <= 1'b0;
          r_pending <= '0;
        end
      endcase
    end
  end

  assign o_pulse    = r_pulse;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_stb_to_pulse.sv
// tb/tb_stb_to_pulse.sv - self-checking bench for stb_to_pulse against a pulse-schedule model
module tb_stb_to_pulse;

  localparam int H = 3;
  localparam int L = 2;
  localparam int Q = 2;

  logic clk = 1'b0;
  logic rst;
  logic stb;
`ifdef STB_TO_PULSE_CANCEL_EN
  logic cancel;
  logic cancel_nxt;
`endif
  logic pulse;
  logic busy;
  logic ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int sched[$];

  // Reference model: start cycle of the latest pulse, queued strobes, pending overflow flag.
  bit m_has;
  int m_start;
  int m_pend;
  bit m_ovf;
  int m_acc;
  int m_drop;

  always #5 clk = ~clk;

  stb_to_pulse #(
    .HIGH_CLKS   (H),
    .LOW_CLKS    (L),
    .QUEUE_DEPTH (Q)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_stb      (stb),
`ifdef STB_TO_PULSE_CANCEL_EN
    .i_cancel   (cancel),
`endif
    .o_pulse    (pulse),
    .o_busy     (busy),
    .o_overflow (ovf)
  );

  function automatic bit m_exp_pulse(input int t);
    return m_has && (t >= m_start) && (t < m_start + H);
  endfunction

  function automatic bit m_exp_busy(input int t);
    return m_has && (t >= m_start) && (t <= m_start + H + L - 1);
  endfunction

  task automatic model_reset();
    m_has = 0; m_start = 0; m_pend = 0; m_ovf = 0; m_acc = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit s, input int t);
    int last;
    last  = m_start + H + L - 1;
    m_ovf = 0;
    if (!m_has || t > last) begin
      if (s) begin m_has = 1; m_start = t + 1; m_acc++; end
    end else if (t == last) begin
      if (m_pend > 0) begin
        m_start = t + 1;
        if (s) m_acc++; else m_pend--;
      end else if (s) begin
        m_start = t + 1; m_acc++;
      end
    end else if (s) begin
      if (m_pend < Q) begin m_pend++; m_acc++; end
      else begin m_ovf = 1; m_drop++; end
    end
  endtask

  task automatic tick(input bit s, output logic op, output logic ob, output logic oo,
                      output bit ep, output bit eb, output bit eo);
    @(negedge clk);
    op = pulse; ob = busy; oo = ovf;
    ep = m_exp_pulse(cyc); eb = m_exp_busy(cyc); eo = m_ovf;
    stb = s;
`ifdef STB_TO_PULSE_CANCEL_EN
    cancel = cancel_nxt;
`endif
    model_step(s, cyc);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stb = 1'b0;
`ifdef STB_TO_PULSE_CANCEL_EN
    cancel = 1'b0;
    cancel_nxt = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    stb = 1'b0;
`ifdef STB_TO_PULSE_CANCEL_EN
    cancel = 1'b0;
    cancel_nxt = 1'b0;
`endif
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pulse, busy, ovf} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_async outputs: got %b exp 000", {pulse, busy, ovf});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pulse, busy, ovf} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_held outputs: got %b exp 000", {pulse, busy, ovf});
    end
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_directed(input string name, input int n_pulses, input int n_ovf);
    logic op, ob, oo, prev;
    bit ep, eb, eo, s;
    int rises, ovfs, first;
    rises = 0; ovfs = 0; first = -1; prev = 1'b0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      s = 0;
      foreach (sched[i]) if (sched[i] == t) s = 1;
      tick(s, op, ob, oo, ep, eb, eo);
      n_checks++;
      if (op !== ep) begin n_errors++; $display("FAIL %s pulse cyc %0d: got %b exp %0b", name, t, op, ep); end
      n_checks++;
      if (ob !== eb) begin n_errors++; $display("FAIL %s busy cyc %0d: got %b exp %0b", name, t, ob, eb); end
      n_checks++;
      if (oo !== eo) begin n_errors++; $display("FAIL %s overflow cyc %0d: got %b exp %0b", name, t, oo, eo); end
      if (op === 1'b1 && prev !== 1'b1) begin rises++; if (first < 0) first = t; end
      if (oo === 1'b1) ovfs++;
      prev = op;
    end
    n_checks++;
    if (rises != n_pulses) begin n_errors++; $display("FAIL %s pulse_count: got %0d exp %0d", name, rises, n_pulses); end
    n_checks++;
    if (ovfs != n_ovf) begin n_errors++; $display("FAIL %s overflow_count: got %0d exp %0d", name, ovfs, n_ovf); end
    n_checks++;
    if (first != sched[0] + 1) begin n_errors++; $display("FAIL %s first_pulse: got %0d exp %0d", name, first, sched[0] + 1); end
  endtask

  task automatic test_async_reset();
    logic op, ob, oo;
    bit ep, eb, eo;
    do_reset();
    for (int t = 0; t <= 12; t++) tick(t >= 10, op, ob, oo, ep, eb, eo);
    n_checks++;
    if (op !== 1'b1) begin n_errors++; $display("FAIL async_rst pre_pulse: got %b exp 1", op); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pulse, busy, ovf} !== 3'b000) begin
      n_errors++;
      $display("FAIL async_rst mid_cycle: got %b exp 000", {pulse, busy, ovf});
    end
    @(negedge clk);
    stb = 1'b0;
    rst = 1'b0;
    model_reset();
    cyc = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1'b0, op, ob, oo, ep, eb, eo);
      n_checks++;
      if ({op, ob, oo} !== 3'b000) begin
        n_errors++;
        $display("FAIL async_rst after_release cyc %0d: got %b exp 000", t, {op, ob, oo});
      end
    end
  endtask

  task automatic test_random();
    logic op, ob, oo, prev;
    bit ep, eb, eo, s, seen;
    int rises, ovfs, hrun, lrun;
    rises = 0; ovfs = 0; hrun = 0; lrun = 0; prev = 1'b0; seen = 0;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      s = (t < 2970) && ($urandom_range(0, 3) == 0);
      tick(s, op, ob, oo, ep, eb, eo);
      n_checks++;
      if ({op, ob, oo} !== {ep, eb, eo}) begin
        n_errors++;
        $display("FAIL random cyc %0d pulse/busy/ovf: got %b exp %b", t, {op, ob, oo}, {ep, eb, eo});
      end
      if (op === 1'b1) begin
        if (prev !== 1'b1) begin
          rises++;
          n_checks++;
          if (seen && lrun < L) begin n_errors++; $display("FAIL random low_gap cyc %0d: got %0d exp >=%0d", t, lrun, L); end
        end
        hrun++;
      end else begin
        if (prev === 1'b1) begin
          seen = 1;
          n_checks++;
          if (hrun != H) begin n_errors++; $display("FAIL random high_width cyc %0d: got %0d exp %0d", t, hrun, H); end
          lrun = 0;
        end
        hrun = 0;
        lrun++;
      end
      if (oo === 1'b1) ovfs++;
      prev = op;
    end
    n_checks++;
    if (rises != m_acc) begin n_errors++; $display("FAIL random conservation: got %0d pulses exp %0d", rises, m_acc); end
    n_checks++;
    if (ovfs != m_drop) begin n_errors++; $display("FAIL random drops: got %0d exp %0d", ovfs, m_drop); end
  endtask

`ifdef STB_TO_PULSE_CANCEL_EN
  task automatic test_cancel();
    logic op, ob, oo;
    bit ep, eb, eo;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      cancel_nxt = (t == 13);
      tick((t >= 10) && (t <= 12), op, ob, oo, ep, eb, eo);
      n_checks++;
      if (op !== ((t >= 11) && (t <= 13))) begin
        n_errors++; $display("FAIL cancel pulse cyc %0d: got %b", t, op);
      end
      n_checks++;
      if (ob !== ((t >= 11) && (t <= 15))) begin
        n_errors++; $display("FAIL cancel busy cyc %0d: got %b", t, ob);
      end
    end
    cancel_nxt = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    sched = '{10};
    test_directed("single", 1, 0);
    sched = '{10, 11, 12};
    test_directed("queued3", 3, 0);
    sched = '{10, 11, 12, 13};
    test_directed("overflow", 3, 1);
    sched = '{10, 15};
    test_directed("last_gap", 2, 0);
    sched = '{10, 11, 12, 13, 18, 20};
    test_directed("back_to_back", 5, 1);
    test_async_reset();
    test_random();
`ifdef STB_TO_PULSE_CANCEL_EN
    test_cancel();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
